// File: rtl/sync_pkg.sv
// -----------------------------------------------------------------------------
// sync_pkg
// Shared constants for the input conditioner: the channel index map of the
// controller's board inputs, the default synchronizer and debounce settings,
// and a helper that sizes the debounce counter.
// Optional feature macro seen by users of this package:
//   INPUT_CONDITIONER_DEBOUNCE_EN
// -----------------------------------------------------------------------------
package sync_pkg;

    // Bit positions of the controller inputs within async_in.
    localparam int CH_SENSOR    = 0;
    localparam int CH_WALK      = 1;
    localparam int CH_REPROGRAM = 2;

    localparam int DEFAULT_CHANNELS        = 3;
    localparam int DEFAULT_STAGES          = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    // The counter must be able to hold the value DEBOUNCE_CYCLES.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage : sync_pkg

// File: rtl/sync_channel.sv
// -----------------------------------------------------------------------------
// sync_channel
// One conditioned input: STAGES-deep synchronizer chain, optional debounce
// filter (INPUT_CONDITIONER_DEBOUNCE_EN), and rise/fall edge detector.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   async_in   in   raw asynchronous input bit
//   reset_sync in   synchronized reset; masks the edge pulses while high
//   level      out  conditioned level
//   rise       out  one-cycle pulse on 0->1 of level
//   fall       out  one-cycle pulse on 1->0 of level
// -----------------------------------------------------------------------------
module sync_channel
    import sync_pkg::*;
#(
    parameter int STAGES = DEFAULT_STAGES
`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
    , parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    input  logic reset_sync,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              s;
    logic              prev;

    // Only chain[0] may go metastable; later stages give it a cycle to settle.
    // NOTE: non-blocking assignments so each stage takes the previous stage's
    // value from before the edge; blocking would collapse the chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
        end
    end

    assign s = chain[STAGES-1];

`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic          d;
    logic [CW-1:0] cnt;

    // cnt counts consecutive cycles in which s disagrees with the accepted
    // level d; any agreeing cycle restarts the count, so short pulses vanish.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d   <= 1'b0;
            cnt <= '0;
        end else if (s == d) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            d   <= s;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign level = d;
`else
    assign level = s;
`endif

    // prev keeps tracking during reset_sync so no stale edge appears when
    // the mask lifts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev & ~reset_sync;
    assign fall = ~level & prev & ~reset_sync;

endmodule : sync_channel

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Multi-channel front end between the board inputs and the traffic-light FSM:
// synchronizes each asynchronous input, optionally debounces it, and emits
// single-cycle rise/fall pulses. Also produces a reset that asserts
// asynchronously and deasserts synchronously for downstream logic.
// Optional feature macro: INPUT_CONDITIONER_DEBOUNCE_EN (debounce filter).
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   async_in   in   [CHANNELS] raw inputs (0 sensor, 1 walk, 2 reprogram)
//   reset_sync out  synchronized reset
//   sync_out   out  [CHANNELS] conditioned levels
//   rise_pulse out  [CHANNELS] 0->1 pulses of sync_out
//   fall_pulse out  [CHANNELS] 1->0 pulses of sync_out
// -----------------------------------------------------------------------------
module input_conditioner
    import sync_pkg::*;
#(
    parameter int CHANNELS        = DEFAULT_CHANNELS,
    parameter int STAGES          = DEFAULT_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] async_in,
    output logic                reset_sync,
    output logic [CHANNELS-1:0] sync_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse
);

    if (CHANNELS < 1) begin : g_chk_channels
        $error("input_conditioner: CHANNELS must be >= 1");
    end
    if (STAGES < 2) begin : g_chk_stages
        $error("input_conditioner: STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_debounce
        $error("input_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end

    // Chain of ones preset by reset; zeros shift in once reset is released,
    // so the release reaches reset_sync on the STAGES-th rising edge.
    logic [STAGES-1:0] rst_chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rst_chain <= '1;
        end else begin
            rst_chain <= {rst_chain[STAGES-2:0], 1'b0};
        end
    end

    assign reset_sync = rst_chain[STAGES-1];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        sync_channel #(
            .STAGES          (STAGES)
`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
            , .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
        ) u_channel (
            .clk        (clk),
            .reset      (reset),
            .async_in   (async_in[i]),
            .reset_sync (reset_sync),
            .level      (sync_out[i]),
            .rise       (rise_pulse[i]),
            .fall       (fall_pulse[i])
        );
    end

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
// Self-checking bench for input_conditioner with default parameters. Works
// with and without INPUT_CONDITIONER_DEBOUNCE_EN; expected values follow the
// build's macro setting.
// -----------------------------------------------------------------------------
module tb_input_conditioner;
    import sync_pkg::*;

    localparam int CH  = 3;
    localparam int ST  = 2;
    localparam int DEB = 4;
`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
    localparam bit DEB_EN = 1'b1;
    localparam int LAT    = ST + DEB;
`else
    localparam bit DEB_EN = 1'b0;
    localparam int LAT    = ST;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [CH-1:0] async_in = '0;
    logic          reset_sync;
    logic [CH-1:0] sync_out;
    logic [CH-1:0] rise_pulse;
    logic [CH-1:0] fall_pulse;

    always #5 clk = ~clk;

    input_conditioner #(
        .CHANNELS        (CH),
        .STAGES          (ST),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .async_in   (async_in),
        .reset_sync (reset_sync),
        .sync_out   (sync_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    typedef struct packed {
        logic          rs;
        logic [CH-1:0] lvl;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Pulse tallies taken from the DUT after each edge.
    int rise_cnt[CH];
    int fall_cnt[CH];
    int all_rise;
    int all_fall;

    // Reference model state.
    logic [ST-1:0] m_rs;
    logic [CH-1:0] m_chain[ST];
    logic [CH-1:0] m_d;
    logic [CH-1:0] m_prev;
    int            m_run[CH];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_clear();
        m_rs   = '1;
        for (int k = 0; k < ST; k++) m_chain[k] = '0;
        m_d    = '0;
        m_prev = '0;
        for (int c = 0; c < CH; c++) m_run[c] = 0;
    endtask

    function automatic obs_t model_out();
        obs_t o;
        o.rs   = m_rs[ST-1];
        o.lvl  = DEB_EN ? m_d : m_chain[ST-1];
        o.rise = o.lvl & ~m_prev & {CH{~o.rs}};
        o.fall = ~o.lvl & m_prev & {CH{~o.rs}};
        return o;
    endfunction

    // Advance the model by one rising edge with input v present before it.
    task automatic model_edge(input logic [CH-1:0] v);
        logic [CH-1:0] s_old;
        if (reset) begin
            model_clear();
            return;
        end
        s_old  = m_chain[ST-1];
        m_prev = DEB_EN ? m_d : s_old;
        for (int c = 0; c < CH; c++) begin
            if (s_old[c] == m_d[c]) begin
                m_run[c] = 0;
            end else begin
                m_run[c]++;
                if (m_run[c] == DEB) begin
                    m_d[c]   = s_old[c];
                    m_run[c] = 0;
                end
            end
        end
        for (int k = ST - 1; k > 0; k--) m_chain[k] = m_chain[k-1];
        m_chain[0] = v;
        m_rs = {m_rs[ST-2:0], 1'b0};
    endtask

    task automatic clear_counts();
        for (int c = 0; c < CH; c++) begin
            rise_cnt[c] = 0;
            fall_cnt[c] = 0;
        end
        all_rise = 0;
        all_fall = 0;
    endtask

    // Drive v, predict the post-edge outputs, then compare after the edge.
    task automatic tick(input logic [CH-1:0] v, input string tag);
        obs_t e;
        async_in = v;
        model_edge(v);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".reset_sync"}, 32'(reset_sync), 32'(e.rs));
        check({tag, ".sync_out"},   32'(sync_out),   32'(e.lvl));
        check({tag, ".rise_pulse"}, 32'(rise_pulse), 32'(e.rise));
        check({tag, ".fall_pulse"}, 32'(fall_pulse), 32'(e.fall));
        for (int c = 0; c < CH; c++) begin
            if (rise_pulse[c]) rise_cnt[c]++;
            if (fall_pulse[c]) fall_cnt[c]++;
        end
        if (rise_pulse == 3'b111) all_rise++;
        if (fall_pulse == 3'b111) all_fall++;
    endtask

    task automatic check_reset_now(input string tag);
        check({tag, ".reset_sync"}, 32'(reset_sync), 32'd1);
        check({tag, ".sync_out"},   32'(sync_out),   32'd0);
        check({tag, ".rise_pulse"}, 32'(rise_pulse), 32'd0);
        check({tag, ".fall_pulse"}, 32'(fall_pulse), 32'd0);
    endtask

    initial begin
        int first;

        clear_counts();

        // Reset asserts between edges; outputs must clear without a clock.
        #3 reset = 1'b1;
        model_clear();
        #1;
        check_reset_now("reset_async");
        tick('0, "reset_hold");
        tick('0, "reset_hold");
        reset = 1'b0;
        tick('0, "release");
        check("release_edge1", 32'(reset_sync), 32'd1);
        tick('0, "release");
        check("release_edge2", 32'(reset_sync), 32'd0);
        repeat (2) tick('0, "idle");

        // Step on the sensor channel.
        clear_counts();
        first = -1;
        for (int i = 0; i < 10; i++) begin
            tick(3'b001, "step0");
            if (first < 0 && sync_out[CH_SENSOR]) first = i;
        end
        check("step0_latency", 32'(first), 32'(LAT - 1));
        check("step0_rise_count", 32'(rise_cnt[CH_SENSOR]), 32'd1);
        check("step0_others_quiet", 32'(rise_cnt[CH_WALK] + rise_cnt[CH_REPROGRAM]), 32'd0);
        repeat (10) tick(3'b000, "step0_back");
        check("step0_fall_count", 32'(fall_cnt[CH_SENSOR]), 32'd1);

        // Three-cycle pulse on walk: filtered only with debounce.
        clear_counts();
        repeat (3) tick(3'b010, "glitch3");
        repeat (10) tick(3'b000, "glitch3_tail");
        check("glitch3_rise", 32'(rise_cnt[CH_WALK]), DEB_EN ? 32'd0 : 32'd1);
        check("glitch3_fall", 32'(fall_cnt[CH_WALK]), DEB_EN ? 32'd0 : 32'd1);

        // Four-cycle pulse on walk: always accepted.
        clear_counts();
        repeat (4) tick(3'b010, "pulse4");
        first = -1;
        for (int i = 0; i < 20; i++) begin
            tick(3'b000, "pulse4_tail");
            if (first < 0 && fall_pulse[CH_WALK]) first = i;
        end
        check("pulse4_rise", 32'(rise_cnt[CH_WALK]), 32'd1);
        check("pulse4_fall_delay", 32'(first), 32'(LAT - 1));

        // Reprogram: step latency, then a one-cycle glitch.
        clear_counts();
        first = -1;
        for (int i = 0; i < 12; i++) begin
            tick(3'b100, "step2");
            if (first < 0 && sync_out[CH_REPROGRAM]) first = i;
        end
        check("step2_latency", 32'(first), 32'(LAT - 1));
        repeat (12) tick(3'b000, "step2_back");
        clear_counts();
        tick(3'b100, "glitch1");
        repeat (10) tick(3'b000, "glitch1_tail");
        check("glitch1_rise", 32'(rise_cnt[CH_REPROGRAM]), DEB_EN ? 32'd0 : 32'd1);
        check("glitch1_fall", 32'(fall_cnt[CH_REPROGRAM]), DEB_EN ? 32'd0 : 32'd1);

        // Reset in the middle of a sensor debounce count (count at 2).
        repeat (4) tick(3'b001, "mid_count");
        #2 reset = 1'b1;
        model_clear();
        #1;
        check_reset_now("reset_mid");
        tick(3'b001, "reset_mid_hold");
        reset = 1'b0;
        clear_counts();
        // Two more high cycles: accepted only if the old count survived.
        repeat (2) tick(3'b001, "after_reset");
        repeat (10) tick(3'b000, "after_reset_tail");
        check("after_reset_rise", 32'(rise_cnt[CH_SENSOR]), DEB_EN ? 32'd0 : 32'd1);

        // All channels move together.
        clear_counts();
        repeat (LAT + 3) tick(3'b111, "all_up");
        check("all_rise_cycles", 32'(all_rise), 32'd1);
        check("all_up_level", 32'(sync_out), 32'd7);
        repeat (LAT + 3) tick(3'b000, "all_down");
        check("all_fall_cycles", 32'(all_fall), 32'd1);
        check("all_down_level", 32'(sync_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_input_conditioner
